// File: rtl/uart_top_rx.sv
// uart_top_rx: receive half of the UART.
// Synchronises the serial line, finds the start edge, samples each bit at
// mid-period with a local baud down-counter, checks optional even parity and
// one or two stop bits, and pushes every completed byte into a show-ahead FIFO.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   rx           serial line, idle high, asynchronous to clk
//   parity_sel   1 = even parity bit present
//   stop_sel     0 = one stop bit, 1 = two stop bits
//   baud_divisor clocks per bit period (values below 4 act as 4)
//   rd_en        pop the FIFO head (ignored when empty)
//   err_clr      clear all sticky error flags
//   rx_data      FIFO head byte, valid while rxfe = 0
//   rxfe / rxff  FIFO empty / full
//   rx_done      one-cycle pulse per completed frame
//   parity_err, frame_err, overrun_err  sticky error flags
module uart_top_rx #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic        parity_sel,
  input  logic        stop_sel,
  input  logic [11:0] baud_divisor,
  input  logic        rd_en,
  input  logic        err_clr,
  output logic [7:0]  rx_data,
  output logic        rxfe,
  output logic        rxff,
  output logic        rx_done,
  output logic        parity_err,
  output logic        frame_err,
  output logic        overrun_err
);

  localparam int unsigned CW = 12;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_t;

  // Line synchroniser and previous-sample register (all idle high)
  logic r_sync1;
  logic r_rx_s;
  logic r_rx_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1   <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= rx;
      r_rx_s    <= r_sync1;
      r_rx_prev <= r_rx_s;
    end
  end

  // Clamped bit period, half period for the start bit, full-period reload
  logic [CW-1:0] w_div;
  logic [CW-1:0] w_half;
  logic [CW-1:0] w_reload;
  logic          w_tick;
  logic          w_fall;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_par_en;
  logic          r_stop2;
  logic          r_par_bad;
  logic          r_frm_bad;
  logic          r_rx_done;

  assign w_div    = (baud_divisor < CW'(4)) ? CW'(4) : baud_divisor;
  assign w_half   = w_div >> 1;
  assign w_reload = w_div - CW'(1);
  assign w_tick   = (r_cnt == '0);
  assign w_fall   = r_rx_prev & ~r_rx_s;

  // Receive FSM; rx_done rises the cycle after the final stop sample while the
  // FSM is already back in IDLE, so a back-to-back start edge is not missed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_par_en  <= 1'b0;
      r_stop2   <= 1'b0;
      r_par_bad <= 1'b0;
      r_frm_bad <= 1'b0;
      r_rx_done <= 1'b0;
    end else begin
      r_rx_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_cnt     <= w_half;
            r_par_en  <= parity_sel;
            r_stop2   <= stop_sel;
            r_par_bad <= 1'b0;
            r_frm_bad <= 1'b0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - CW'(1);
          end else if (!r_rx_s) begin
            r_cnt    <= w_reload;
            r_bitcnt <= '0;
            r_state  <= S_DATA;
          end else begin
            // Line went back high before mid-bit: glitch, not a start bit
            r_state <= S_IDLE;
          end
        end
        S_DATA: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_shift  <= {r_rx_s, r_shift[7:1]};
            r_cnt    <= w_reload;
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              r_state <= r_par_en ? S_PARITY : S_STOP1;
            end
          end
        end
        S_PARITY: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_par_bad <= (^r_shift) ^ r_rx_s;
            r_cnt     <= w_reload;
            r_state   <= S_STOP1;
          end
        end
        S_STOP1: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_frm_bad <= ~r_rx_s;
            if (r_stop2) begin
              r_cnt   <= w_reload;
              r_state <= S_STOP2;
            end else begin
              r_rx_done <= 1'b1;
              r_state   <= S_IDLE;
            end
          end
        end
        S_STOP2: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_frm_bad <= r_frm_bad | ~r_rx_s;
            r_rx_done <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Show-ahead FIFO with one extra pointer bit to tell full from empty
  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_wr;
  logic          w_ovr;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_pop   = rd_en & ~w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign w_wr    = r_rx_done & (~w_full | w_pop);
  assign w_ovr   = r_rx_done & w_full & ~rd_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
    end
  end

  // Sticky error flags: a new event wins over a simultaneous clear
  logic r_parity_err;
  logic r_frame_err;
  logic r_overrun_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_parity_err  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_parity_err  <= (r_rx_done & r_par_bad) | (r_parity_err & ~err_clr);
      r_frame_err   <= (r_rx_done & r_frm_bad) | (r_frame_err & ~err_clr);
      r_overrun_err <= w_ovr | (r_overrun_err & ~err_clr);
    end
  end

  assign rx_data     = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
  assign rxfe        = w_empty;
  assign rxff        = w_full;
  assign rx_done     = r_rx_done;
  assign parity_err  = r_parity_err;
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun_err;

endmodule

// File: tb/tb_uart_top_rx.sv
// Self-checking bench for uart_top_rx: drives serial frames, keeps a byte-level
// reference (expected FIFO contents and per-frame error flags) in queues, and
// lets independent monitors compare completed frames and popped bytes.
module tb_uart_top_rx;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic        parity_sel;
  logic        stop_sel;
  logic [11:0] baud_divisor;
  logic        rd_en;
  logic        err_clr;
  logic [7:0]  rx_data;
  logic        rxfe;
  logic        rxff;
  logic        rx_done;
  logic        parity_err;
  logic        frame_err;
  logic        overrun_err;

  uart_top_rx #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .parity_sel  (parity_sel),
    .stop_sel    (stop_sel),
    .baud_divisor(baud_divisor),
    .rd_en       (rd_en),
    .err_clr     (err_clr),
    .rx_data     (rx_data),
    .rxfe        (rxfe),
    .rxff        (rxff),
    .rx_done     (rx_done),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } exp_t;

  exp_t       done_q[$];
  logic [7:0] rd_q[$];
  int         checks = 0;
  int         errors = 0;
  int         d_eff  = 16;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 2 time units past the edge
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_baud(input int div);
    baud_divisor = 12'(div);
    d_eff = (div < 4) ? 4 : div;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    cyc(d_eff);
  endtask

  // Serial frame plus reference-model update for the bytes and flags it implies
  task automatic send_frame(input logic [7:0] data, input bit par_on, input bit bad_par,
                            input bit two_stop, input bit bad_stop1, input bit bad_stop2,
                            input int gap_bits, input bit clr);
    exp_t f;
    logic pbit;
    if (clr) begin
      err_clr = 1'b1;
      cyc(1);
      err_clr = 1'b0;
    end
    parity_sel = par_on;
    stop_sel   = two_stop;
    pbit   = (^data) ^ bad_par;
    f.data = data;
    f.perr = par_on && ((($countones(data) + int'(pbit)) % 2) == 1);
    f.ferr = bad_stop1 || (two_stop && bad_stop2);
    f.ovr  = (rd_q.size() == DEPTH);
    if (!f.ovr) rd_q.push_back(data);
    done_q.push_back(f);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    if (par_on) drive_bit(pbit);
    drive_bit(~bad_stop1);
    if (two_stop) drive_bit(~bad_stop2);
    rx = 1'b1;
    if (gap_bits > 0) cyc(gap_bits * d_eff);
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1;
      cyc(1);
    end
    rd_en = 1'b0;
    cyc(1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rx_data", 32'(rx_data), 32'h00);
    chk("rst_rxfe", 32'(rxfe), 32'd1);
    chk("rst_rxff", 32'(rxff), 32'd0);
    chk("rst_rx_done", 32'(rx_done), 32'd0);
    chk("rst_parity_err", 32'(parity_err), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overrun_err", 32'(overrun_err), 32'd0);
  endtask

  // Frame-completion monitor: every rx_done must match the oldest expected frame
  initial begin
    exp_t f;
    forever begin
      @(negedge clk);
      if (rx_done === 1'b1) begin
        if (done_q.size() == 0) begin
          chk("unexpected_rx_done", 32'(rx_done), 32'd0);
        end else begin
          f = done_q.pop_front();
          @(negedge clk);
          chk("rx_done_pulse", 32'(rx_done), 32'd0);
          chk("parity_err", 32'(parity_err), 32'(f.perr));
          chk("frame_err", 32'(frame_err), 32'(f.ferr));
          chk("overrun_err", 32'(overrun_err), 32'(f.ovr));
        end
      end
    end
  end

  // Read monitor: every accepted pop must present the oldest expected byte
  initial begin
    forever begin
      @(negedge clk);
      if (rd_en === 1'b1 && rxfe === 1'b0) begin
        if (rd_q.size() == 0) chk("unexpected_pop_data", 32'(rxfe), 32'd1);
        else chk("rx_data", 32'(rx_data), 32'(rd_q.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rx = 1'b1; parity_sel = 1'b0; stop_sel = 1'b0;
    rd_en = 1'b0; err_clr = 1'b0;
    set_baud(16);
    cyc(3);
    chk_reset_outputs();
    reset = 1'b0;
    cyc(3);

    // Basic 8N1 frame
    send_frame(8'hA5, 0, 0, 0, 0, 0, 2, 1);
    chk("a5_rxfe", 32'(rxfe), 32'd0);
    chk("a5_head", 32'(rx_data), 32'hA5);
    pop_n(1);
    chk("a5_empty_after_pop", 32'(rxfe), 32'd1);

    // Wrong even-parity bit, then clear the sticky flag
    send_frame(8'h3C, 1, 1, 0, 0, 0, 2, 1);
    chk("3c_head", 32'(rx_data), 32'h3C);
    pop_n(1);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    chk("parity_err_cleared", 32'(parity_err), 32'd0);

    // Second stop bit low: byte still stored
    send_frame(8'h81, 0, 0, 1, 0, 1, 2, 1);
    chk("81_head", 32'(rx_data), 32'h81);
    pop_n(1);

    // 4-clock glitch is rejected; a real frame afterwards still works
    rx = 1'b0;
    cyc(4);
    rx = 1'b1;
    cyc(3 * d_eff);
    chk("glitch_rxfe", 32'(rxfe), 32'd1);
    send_frame(8'h5A, 1, 0, 0, 0, 0, 2, 1);
    pop_n(rd_q.size());

    // Fill, overrun, drain; twice so the pointers wrap
    set_baud(8);
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 1; i <= 9; i++) begin
        send_frame(8'(i + rep * 16), 0, 0, 0, 0, 0, 1, 1);
        if (i == 8) chk("rxff_after_8", 32'(rxff), 32'd1);
      end
      pop_n(8);
      chk("rxfe_after_drain", 32'(rxfe), 32'd1);
      chk("rxff_after_drain", 32'(rxff), 32'd0);
    end

    // Divisors below 4 run at 4 clocks per bit
    set_baud(2);
    send_frame(8'hC6, 1, 0, 1, 0, 0, 2, 1);
    set_baud(3);
    send_frame(8'h39, 0, 0, 0, 0, 0, 2, 1);
    pop_n(rd_q.size());

    // Randomised frame formats, rates, errors and partial drains
    for (int n = 0; n < 30; n++) begin
      set_baud(int'($urandom_range(4, 40)));
      send_frame(8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 5) == 0), 2, 1);
      if ($urandom_range(0, 2) == 0) pop_n(int'($urandom_range(0, rd_q.size())));
    end
    pop_n(rd_q.size());
    chk("random_drained_rxfe", 32'(rxfe), 32'd1);

    // Back-to-back frames, then reset in the middle of a third
    set_baud(16);
    send_frame(8'h55, 0, 0, 0, 0, 0, 0, 1);
    send_frame(8'hAA, 1, 1, 0, 0, 0, 0, 0);
    rx = 1'b0;
    cyc(d_eff);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    chk("b2b_fifo_nonempty", 32'(rxfe), 32'd0);
    chk("b2b_parity_err_set", 32'(parity_err), 32'd1);
    reset = 1'b1;
    rx = 1'b1;
    rd_q.delete();
    done_q.delete();
    cyc(2);
    chk_reset_outputs();
    reset = 1'b0;
    cyc(4);
    send_frame(8'hC3, 0, 0, 0, 0, 0, 2, 1);
    pop_n(rd_q.size());

    // Line held low through reset release reads as 0x00 with a framing error
    reset = 1'b1;
    rx = 1'b0;
    parity_sel = 1'b0;
    stop_sel = 1'b0;
    cyc(2);
    done_q.push_back('{data: 8'h00, perr: 1'b0, ferr: 1'b1, ovr: 1'b0});
    rd_q.push_back(8'h00);
    reset = 1'b0;
    cyc(11 * d_eff);
    rx = 1'b1;
    cyc(3 * d_eff);
    chk("low_release_rxfe", 32'(rxfe), 32'd0);
    pop_n(1);
    send_frame(8'h7E, 0, 0, 0, 0, 0, 2, 1);
    pop_n(rd_q.size());

    cyc(20);
    chk("frames_outstanding", 32'(done_q.size()), 32'd0);
    chk("bytes_outstanding", 32'(rd_q.size()), 32'd0);
    chk("final_rxfe", 32'(rxfe), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
